// File: rtl/csr_file.sv
// Machine-mode CSR file serving the trap-unit port and the execute-stage Zicsr port.
// Latency: reads are combinational from current state; writes land on the next clk edge; mip samples with 1 cycle delay.
// Backpressure: none; both ports are accepted every cycle, trap port wins a same-address write collision.
module csr_file #(
    parameter logic [31:0] MISA_VAL = 32'h4000_1100,
    parameter logic [31:0] HART_ID  = 32'd0,
    parameter bit          CNT_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] trap_csr_addr_i,
    input  logic        trap_csr_we_i,
    input  logic [31:0] trap_csr_wdata_i,
    output logic [31:0] trap_csr_rdata_o,
    input  logic [11:0] ex_csr_addr_i,
    input  logic        ex_csr_we_i,
    input  logic [31:0] ex_csr_wdata_i,
    output logic [31:0] ex_csr_rdata_o,
    output logic        ex_csr_err_o,
    input  logic        inst_retire_i,
    input  logic        pex_irq_i,
    input  logic        ptcmp_irq_i,
    input  logic        psoft_irq_i,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mstatus_mie_o,
    output logic        irq_pending_o
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    // Writable-bit masks; MPP is hardwired to M-mode and added on read.
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
    localparam logic [31:0] ALIGN4_WMASK  = 32'hFFFF_FFFC;

    logic [31:0] mstatus_q, mie_q, mtvec_q, mepc_q, mscratch_q, mcause_q, mtval_q;
    logic [2:0]  mip_q;      // {MEIP, MTIP, MSIP}
    logic [63:0] mcycle_q, minstret_q;
    logic [31:0] mip_vec;

    logic [32:0] w_mstatus, w_mie, w_mtvec, w_mepc, w_mscratch, w_mcause, w_mtval;
    logic [32:0] w_mcycle, w_mcycleh, w_minstret, w_minstreth;

    // Merge both ports for one address: {hit, data}; trap port takes priority.
    function automatic logic [32:0] wr_sel(input logic [11:0] a);
        if (trap_csr_we_i && trap_csr_addr_i == a)
            wr_sel = {1'b1, trap_csr_wdata_i};
        else if (ex_csr_we_i && ex_csr_addr_i == a)
            wr_sel = {1'b1, ex_csr_wdata_i};
        else
            wr_sel = 33'd0;
    endfunction

    // Read mux shared by both ports.
    function automatic logic [31:0] csr_read(input logic [11:0] a);
        case (a)
            A_MSTATUS:   csr_read = mstatus_q | MSTATUS_FIXED;
            A_MISA:      csr_read = MISA_VAL;
            A_MIE:       csr_read = mie_q;
            A_MTVEC:     csr_read = mtvec_q;
            A_MSCRATCH:  csr_read = mscratch_q;
            A_MEPC:      csr_read = mepc_q;
            A_MCAUSE:    csr_read = mcause_q;
            A_MTVAL:     csr_read = mtval_q;
            A_MIP:       csr_read = mip_vec;
            A_MCYCLE:    csr_read = mcycle_q[31:0];
            A_MCYCLEH:   csr_read = mcycle_q[63:32];
            A_MINSTRET:  csr_read = minstret_q[31:0];
            A_MINSTRETH: csr_read = minstret_q[63:32];
            A_MHARTID:   csr_read = HART_ID;
            default:     csr_read = 32'd0;
        endcase
    endfunction

    function automatic logic csr_impl(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MISA, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
            A_MTVAL, A_MIP, A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH,
            A_MHARTID: csr_impl = 1'b1;
            default:   csr_impl = 1'b0;
        endcase
    endfunction

    function automatic logic csr_ro(input logic [11:0] a);
        csr_ro = (a == A_MISA) || (a == A_MIP) || (a == A_MHARTID);
    endfunction

    assign w_mstatus   = wr_sel(A_MSTATUS);
    assign w_mie       = wr_sel(A_MIE);
    assign w_mtvec     = wr_sel(A_MTVEC);
    assign w_mepc      = wr_sel(A_MEPC);
    assign w_mscratch  = wr_sel(A_MSCRATCH);
    assign w_mcause    = wr_sel(A_MCAUSE);
    assign w_mtval     = wr_sel(A_MTVAL);
    assign w_mcycle    = wr_sel(A_MCYCLE);
    assign w_mcycleh   = wr_sel(A_MCYCLEH);
    assign w_minstret  = wr_sel(A_MINSTRET);
    assign w_minstreth = wr_sel(A_MINSTRETH);

    assign mip_vec = {20'd0, mip_q[2], 3'd0, mip_q[1], 3'd0, mip_q[0], 3'd0};

    assign trap_csr_rdata_o = csr_read(trap_csr_addr_i);
    assign ex_csr_rdata_o   = csr_read(ex_csr_addr_i);
    assign ex_csr_err_o     = !csr_impl(ex_csr_addr_i) || (ex_csr_we_i && csr_ro(ex_csr_addr_i));

    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;
    assign mstatus_mie_o = mstatus_q[3];
    assign irq_pending_o = mstatus_q[3] & (|(mie_q & mip_vec));

    // CSR state update: masked writes, interrupt sampling, 64-bit counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q  <= 32'd0;
            mie_q      <= 32'd0;
            mtvec_q    <= 32'd0;
            mepc_q     <= 32'd0;
            mscratch_q <= 32'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
            mip_q      <= 3'd0;
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            if (w_mstatus[32])  mstatus_q  <= w_mstatus[31:0] & MSTATUS_WMASK;
            if (w_mie[32])      mie_q      <= w_mie[31:0] & MIE_WMASK;
            if (w_mtvec[32])    mtvec_q    <= w_mtvec[31:0] & ALIGN4_WMASK;
            if (w_mepc[32])     mepc_q     <= w_mepc[31:0] & ALIGN4_WMASK;
            if (w_mscratch[32]) mscratch_q <= w_mscratch[31:0];
            if (w_mcause[32])   mcause_q   <= w_mcause[31:0];
            if (w_mtval[32])    mtval_q    <= w_mtval[31:0];

            mip_q <= {pex_irq_i, ptcmp_irq_i, psoft_irq_i};

            // A write to either half freezes the whole counter for that cycle.
            if (w_mcycle[32] || w_mcycleh[32]) begin
                if (w_mcycle[32])  mcycle_q[31:0]  <= w_mcycle[31:0];
                if (w_mcycleh[32]) mcycle_q[63:32] <= w_mcycleh[31:0];
            end else if (CNT_EN) begin
                mcycle_q <= mcycle_q + 64'd1;
            end

            if (w_minstret[32] || w_minstreth[32]) begin
                if (w_minstret[32])  minstret_q[31:0]  <= w_minstret[31:0];
                if (w_minstreth[32]) minstret_q[63:32] <= w_minstreth[31:0];
            end else if (CNT_EN && inst_retire_i) begin
                minstret_q <= minstret_q + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed literal checks plus randomized traffic against a table-driven CSR model.
// Model state advances on each posedge from the inputs driven 1 ns after the previous edge.
// Outputs are compared on every negedge once reset has been seen.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] trap_addr, ex_addr;
    logic        trap_we, ex_we;
    logic [31:0] trap_wdata, ex_wdata;
    logic [31:0] trap_rdata, ex_rdata;
    logic        ex_err;
    logic        retire, pex, ptcmp, psoft;
    logic [31:0] mtvec, mepc;
    logic        mie_bit, irq_pend;

    int n_tests = 0;
    int n_fail  = 0;

    csr_file dut (
        .clk              (clk),
        .rst              (rst),
        .trap_csr_addr_i  (trap_addr),
        .trap_csr_we_i    (trap_we),
        .trap_csr_wdata_i (trap_wdata),
        .trap_csr_rdata_o (trap_rdata),
        .ex_csr_addr_i    (ex_addr),
        .ex_csr_we_i      (ex_we),
        .ex_csr_wdata_i   (ex_wdata),
        .ex_csr_rdata_o   (ex_rdata),
        .ex_csr_err_o     (ex_err),
        .inst_retire_i    (retire),
        .pex_irq_i        (pex),
        .ptcmp_irq_i      (ptcmp),
        .psoft_irq_i      (psoft),
        .mtvec_o          (mtvec),
        .mepc_o           (mepc),
        .mstatus_mie_o    (mie_bit),
        .irq_pending_o    (irq_pend)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit [31:0] mreg [0:4095];
    bit [63:0] mcyc, mret;
    bit [31:0] mmip;
    bit        mvalid = 1'b0;

    function automatic bit [31:0] wmask(input bit [11:0] a);
        case (a)
            12'h300:                   return 32'h0000_0088;
            12'h304:                   return 32'h0000_0888;
            12'h305, 12'h341:          return 32'hFFFF_FFFC;
            12'h340, 12'h342, 12'h343: return 32'hFFFF_FFFF;
            default:                   return 32'h0;
        endcase
    endfunction

    function automatic bit is_impl(input bit [11:0] a);
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14};
    endfunction

    function automatic bit is_ro(input bit [11:0] a);
        return a inside {12'h301, 12'h344, 12'hF14};
    endfunction

    function automatic bit [31:0] model_read(input bit [11:0] a);
        case (a)
            12'h300: return mreg[a] | 32'h0000_1800;
            12'h301: return 32'h4000_1100;
            12'h344: return mmip;
            12'hB00: return mcyc[31:0];
            12'hB80: return mcyc[63:32];
            12'hB02: return mret[31:0];
            12'hB82: return mret[63:32];
            default: return mreg[a];
        endcase
    endfunction

    task automatic model_write(input bit [11:0] a, input bit [31:0] d);
        case (a)
            12'hB00: mcyc = {mcyc[63:32], d};
            12'hB80: mcyc = {d, mcyc[31:0]};
            12'hB02: mret = {mret[63:32], d};
            12'hB82: mret = {d, mret[31:0]};
            default: if (wmask(a) != 0) mreg[a] = d & wmask(a);
        endcase
    endtask

    // Advance the model one clock: increments first, then ex write, then trap write so trap wins.
    always @(posedge clk) begin
        bit cyc_w, ret_w;
        if (rst) begin
            mreg   = '{default: 32'h0};
            mcyc   = 64'd0;
            mret   = 64'd0;
            mmip   = 32'd0;
            mvalid = 1'b1;
        end else begin
            cyc_w = (ex_we && ex_addr inside {12'hB00, 12'hB80}) ||
                    (trap_we && trap_addr inside {12'hB00, 12'hB80});
            ret_w = (ex_we && ex_addr inside {12'hB02, 12'hB82}) ||
                    (trap_we && trap_addr inside {12'hB02, 12'hB82});
            if (!cyc_w) mcyc = mcyc + 64'd1;
            if (!ret_w && retire) mret = mret + 64'd1;
            if (ex_we)   model_write(ex_addr, ex_wdata);
            if (trap_we) model_write(trap_addr, trap_wdata);
            mmip = (32'(psoft) << 3) | (32'(ptcmp) << 7) | (32'(pex) << 11);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (mvalid && !rst) begin
            check("trap_rdata", trap_rdata, model_read(trap_addr));
            check("ex_rdata", ex_rdata, model_read(ex_addr));
            check("ex_err", 32'(ex_err), 32'(!is_impl(ex_addr) || (ex_we && is_ro(ex_addr))));
            check("mtvec_o", mtvec, mreg[12'h305]);
            check("mepc_o", mepc, mreg[12'h341]);
            check("mstatus_mie_o", 32'(mie_bit), 32'(mreg[12'h300][3]));
            check("irq_pending_o", 32'(irq_pend), 32'(mreg[12'h300][3] && ((mreg[12'h304] & mmip) != 0)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        trap_we = 1'b0; ex_we = 1'b0;
    endtask

    bit [11:0] alist [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                              12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'h000};
    bit [11:0] rst_addr [10] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                 12'h344, 12'hF14};
    bit [31:0] rst_exp  [10] = '{32'h1800, 32'h4000_1100, 0, 0, 0, 0, 0, 0, 0, 0};
    bit [11:0] ones_addr [4] = '{12'h300, 12'h304, 12'h305, 12'h341};
    bit [31:0] ones_exp  [4] = '{32'h0000_1888, 32'h0000_0888, 32'hFFFF_FFFC, 32'hFFFF_FFFC};

    initial begin
        rst = 1'b1; trap_addr = 12'h0; ex_addr = 12'h0; trap_we = 0; ex_we = 0;
        trap_wdata = 0; ex_wdata = 0; retire = 0; pex = 0; ptcmp = 0; psoft = 0;
        repeat (2) cyc();
        rst = 1'b0;

        // Reset values; counters read in the first cycle out of reset.
        trap_addr = 12'hB00; ex_addr = 12'hB80; #1;
        check("rst_mcycle", trap_rdata, 32'h0);
        check("rst_mcycleh", ex_rdata, 32'h0);
        trap_addr = 12'hB02; ex_addr = 12'hB82; #1;
        check("rst_minstret", trap_rdata, 32'h0);
        check("rst_minstreth", ex_rdata, 32'h0);
        check("model_rst_mstatus", model_read(12'h300), 32'h1800);
        check("rst_mtvec_o", mtvec, 32'h0);
        check("rst_mepc_o", mepc, 32'h0);
        check("rst_mie_o", 32'(mie_bit), 32'h0);
        check("rst_irq_o", 32'(irq_pend), 32'h0);
        for (int i = 0; i < 10; i++) begin
            trap_addr = rst_addr[i]; ex_addr = rst_addr[i]; #1;
            check("rst_trap_read", trap_rdata, rst_exp[i]);
            check("rst_ex_read", ex_rdata, rst_exp[i]);
        end
        cyc();

        // All-ones writes through the ex port.
        for (int i = 0; i < 4; i++) begin
            ex_addr = ones_addr[i]; ex_we = 1; ex_wdata = 32'hFFFF_FFFF;
            cyc();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            ex_addr = ones_addr[i]; #1;
            check("ones_read", ex_rdata, ones_exp[i]);
        end
        check("ones_mie_o", 32'(mie_bit), 32'h1);
        check("ones_mtvec_o", mtvec, 32'hFFFF_FFFC);
        cyc();

        // Timer interrupt path.
        ex_addr = 12'h304; ex_we = 1; ex_wdata = 32'h80;
        trap_addr = 12'h300; trap_we = 1; trap_wdata = 32'h8;
        cyc();
        idle();
        ptcmp = 1;
        ex_addr = 12'h344; #1;
        check("mip_before_sample", ex_rdata, 32'h0);
        check("irq_before_sample", 32'(irq_pend), 32'h0);
        cyc();
        check("mip_timer", ex_rdata, 32'h80);
        check("irq_timer", 32'(irq_pend), 32'h1);
        trap_addr = 12'h300; trap_we = 1; trap_wdata = 32'h0;
        cyc();
        idle();
        check("irq_mie_clear", 32'(irq_pend), 32'h0);
        check("mip_held", ex_rdata, 32'h80);
        ptcmp = 0;
        cyc();

        // Counter carry across halves.
        ex_addr = 12'hB00; ex_we = 1; ex_wdata = 32'hFFFF_FFFE;
        cyc();
        ex_addr = 12'hB80; ex_wdata = 32'h0;
        cyc();
        idle();
        repeat (2) cyc();
        trap_addr = 12'hB00; ex_addr = 12'hB80; #1;
        check("carry_mcycle", trap_rdata, 32'h0);
        check("carry_mcycleh", ex_rdata, 32'h1);
        cyc();
        trap_addr = 12'hB00; trap_we = 1; trap_wdata = 32'hFFFF_FFFF;
        ex_addr = 12'hB80; ex_we = 1; ex_wdata = 32'hFFFF_FFFF;
        cyc();
        idle();
        check("allones_mcycle", trap_rdata, 32'hFFFF_FFFF);
        check("allones_mcycleh", ex_rdata, 32'hFFFF_FFFF);
        cyc();
        check("wrap_mcycle", trap_rdata, 32'h0);
        check("wrap_mcycleh", ex_rdata, 32'h0);

        // Same-address collision and error flag.
        trap_addr = 12'h341; trap_we = 1; trap_wdata = 32'h100;
        ex_addr = 12'h341; ex_we = 1; ex_wdata = 32'h200;
        cyc();
        idle();
        check("collision_mepc", mepc, 32'h100);
        ex_addr = 12'h344; ex_we = 1; ex_wdata = 32'hFFFF_FFFF; #1;
        check("err_ro_write", 32'(ex_err), 32'h1);
        cyc();
        ex_we = 0; #1;
        check("mip_unchanged", ex_rdata, 32'h0);
        check("err_ro_read", 32'(ex_err), 32'h0);
        ex_addr = 12'h7C0; #1;
        check("err_unmapped", 32'(ex_err), 32'h1);
        cyc();

        // Reset during a write and an increment.
        ex_addr = 12'h340; ex_we = 1; ex_wdata = 32'h1234_5678; retire = 1; rst = 1;
        cyc();
        rst = 0; idle(); retire = 0;
        trap_addr = 12'hB00; #1;
        check("midrst_mscratch", ex_rdata, 32'h0);
        check("midrst_mcycle", trap_rdata, 32'h0);
        cyc();
        check("resume_mcycle", trap_rdata, 32'h1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            trap_addr  = alist[$urandom_range(0, 15)];
            ex_addr    = ($urandom_range(0, 3) == 0) ? trap_addr : alist[$urandom_range(0, 15)];
            trap_we    = ($urandom_range(0, 3) == 0);
            ex_we      = ($urandom_range(0, 2) == 0);
            trap_wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
            ex_wdata   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
            retire     = $urandom_range(0, 1);
            pex        = $urandom_range(0, 1);
            ptcmp      = $urandom_range(0, 1);
            psoft      = $urandom_range(0, 1);
            rst        = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 0; idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
